// File: rtl/grf_multiport.sv
// grf_multiport: parametrised MIPS general register file, NUM_RD combinational
//   read ports, one synchronous write port, optional write-to-read bypass and
//   hardwired-zero register 0. Synchronous active-low clear (clr).
// Ports: clk, clr (sync, active-low), we/waddr/wdata/wpc (write side),
//   raddr (packed NUM_RD*AW read indices), rdata (packed NUM_RD*DW read data).
// Config macro: GRF_TRACE_EN -- when defined, prints "@pc: $idx <= data" on
//   every committed write; otherwise wpc is unused and no trace is compiled.
module grf_multiport #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [DW-1:0]        wdata,
   input  logic [31:0]          wpc,
   input  logic [NUM_RD*AW-1:0] raddr,
   output logic [NUM_RD*DW-1:0] rdata
);

   // Elaboration-time parameter sanity.
   if (AW != $clog2(DEPTH)) begin : g_bad_aw
      $error("grf_multiport: AW (%0d) must equal $clog2(DEPTH=%0d)", AW, DEPTH);
   end
   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_nrd
      $error("grf_multiport: NUM_RD (%0d) must be in 1..4", NUM_RD);
   end

   logic [DW-1:0] regs_q [DEPTH];
   logic          wr_commit;
   logic          wr_to_zero;

   // A register-0 write is dropped when register 0 is hardwired.
   assign wr_to_zero = (ZERO_REG != 0) && (waddr == '0);
   assign wr_commit  = clr && we && !wr_to_zero;

   // Clear has priority over write; a write in a clear cycle is lost.
   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
         end
      end else if (wr_commit) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Zero-register check wins over bypass, so a pending write to register 0
   // never leaks onto a read port. Bypass is suppressed while clr is low.
   always_comb begin
      rdata = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if ((ZERO_REG != 0) && (raddr[p*AW +: AW] == '0)) begin
            rdata[p*DW +: DW] = '0;
         end else if ((BYPASS != 0) && clr && we && (waddr == raddr[p*AW +: AW])) begin
            rdata[p*DW +: DW] = wdata;
         end else begin
            rdata[p*DW +: DW] = regs_q[raddr[p*AW +: AW]];
         end
      end
   end

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         $display("@%h: $%d <= %h", wpc, waddr, wdata);
      end
   end
`else
   logic unused_wpc;
   assign unused_wpc = ^wpc;
`endif

endmodule
